// File: rtl/nds_capture_pkg.sv
// nds_capture_pkg: shared types and default geometry for the NDS line grabber.
package nds_capture_pkg;

    localparam int H_PORCH_DEF  = 4;
    localparam int H_ACTIVE_DEF = 256;
    localparam int V_ACTIVE_DEF = 192;

    typedef logic [17:0] pixel_t;

    typedef enum logic [2:0] {
        WAIT_FRAME,
        WAIT_LINE,
        PORCH,
        ACTIVE,
        TAIL
    } cap_state_t;

endpackage

// File: rtl/nds_capture_sync_edge.sv
// nds_sync_edge: 2-FF synchronizer for one asynchronous NDS control pin,
// with rise/fall pulses taken from the synchronized level and its delayed copy.
module nds_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/nds_line_capture.sv
// nds_line_capture: grabs NDS LCD lines into ping-pong line buffers.
// Define NDS_CAPTURE_DUAL_EDGE_EN to also capture screen B on pix_clk falls.
module nds_line_capture
    import nds_capture_pkg::*;
#(
    parameter int H_PORCH  = H_PORCH_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nds_pix_clk,
    input  logic        nds_hsync,
    input  logic        nds_vsync,
    input  logic [17:0] nds_data,
    output logic        wr_en_a,
    output logic        wr_en_b,
    output logic        wr_bank,
    output logic [7:0]  wr_addr,
    output logic [17:0] wr_data,
    output logic        line_done,
    output logic [7:0]  line_num,
    output logic        frame_start,
    output logic        short_line
);

    localparam int CW = $clog2(H_PORCH + H_ACTIVE + 1);
    localparam logic [CW-1:0] PORCH_W    = CW'(H_PORCH);
    localparam logic [CW-1:0] PORCH_LAST = CW'(H_PORCH - 1);
    localparam logic [CW-1:0] ACT_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [7:0]    LINE_LAST  = 8'(V_ACTIVE - 1);
    localparam cap_state_t    LINE_ENTRY = (H_PORCH == 0) ? ACTIVE : PORCH;

    logic w_pix_rise;
    logic w_pix_fall;
    logic w_hs_rise;
    logic w_hs_fall;
    logic w_vs_rise;
    logic w_vs_fall;

    nds_sync_edge u_sync_pix (
        .clk     (clk),
        .rst     (rst),
        .i_async (nds_pix_clk),
        .o_rise  (w_pix_rise),
        .o_fall  (w_pix_fall)
    );

    nds_sync_edge u_sync_hs (
        .clk     (clk),
        .rst     (rst),
        .i_async (nds_hsync),
        .o_rise  (w_hs_rise),
        .o_fall  (w_hs_fall)
    );

    nds_sync_edge u_sync_vs (
        .clk     (clk),
        .rst     (rst),
        .i_async (nds_vsync),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    // Data is delayed two stages so r_d2 lines up with the edge pulses.
    pixel_t r_d1;
    pixel_t r_d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            r_d1 <= nds_data;
            r_d2 <= r_d1;
        end
    end

    cap_state_t    r_state;
    cap_state_t    w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_act_addr;
    logic          w_wr_a;
    logic [7:0]    w_addr;
    pixel_t        w_data;
    logic          w_done;
    logic          w_fs;
    logic          w_bank;
    logic [7:0]    w_line;
    logic          w_short;
`ifdef NDS_CAPTURE_DUAL_EDGE_EN
    logic          r_pend;
    logic          w_pend_nx;
    logic          w_wr_b;
`endif

    assign w_act_addr = r_cnt - PORCH_W;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_wr_a     = 1'b0;
        w_addr     = wr_addr;
        w_data     = wr_data;
        w_done     = 1'b0;
        w_fs       = 1'b0;
        w_bank     = wr_bank;
        w_line     = line_num;
        w_short    = short_line;
`ifdef NDS_CAPTURE_DUAL_EDGE_EN
        w_pend_nx  = r_pend;
        w_wr_b     = 1'b0;
`endif
        if (w_vs_fall) begin
            w_fs       = 1'b1;
            w_line     = '0;
            w_bank     = 1'b0;
            w_cnt_nx   = '0;
            w_state_nx = WAIT_LINE;
`ifdef NDS_CAPTURE_DUAL_EDGE_EN
            w_pend_nx  = 1'b0;
`endif
        end else if (w_hs_fall) begin
            // Any pixel edge coinciding with hsync fall is dropped here.
            w_cnt_nx = '0;
`ifdef NDS_CAPTURE_DUAL_EDGE_EN
            w_pend_nx = 1'b0;
`endif
            case (r_state)
                WAIT_LINE: w_state_nx = LINE_ENTRY;
                PORCH, ACTIVE: begin
                    w_short    = 1'b1;
                    w_state_nx = LINE_ENTRY;
                end
                TAIL: begin
                    w_done     = 1'b1;
                    w_bank     = ~wr_bank;
                    w_line     = line_num + 8'd1;
                    w_state_nx = (line_num == LINE_LAST) ? WAIT_FRAME
                                                         : LINE_ENTRY;
                end
                default: w_cnt_nx = r_cnt;
            endcase
        end else if (w_pix_rise) begin
            case (r_state)
                PORCH: begin
                    w_cnt_nx = r_cnt + 1'b1;
                    if (r_cnt == PORCH_LAST)
                        w_state_nx = ACTIVE;
                end
                ACTIVE: begin
                    w_wr_a   = 1'b1;
                    w_addr   = 8'(w_act_addr);
                    w_data   = r_d2;
                    w_cnt_nx = r_cnt + 1'b1;
`ifdef NDS_CAPTURE_DUAL_EDGE_EN
                    w_pend_nx = 1'b1;
`endif
                    if (w_act_addr == ACT_LAST)
                        w_state_nx = TAIL;
                end
                default: w_cnt_nx = r_cnt;
            endcase
        end
`ifdef NDS_CAPTURE_DUAL_EDGE_EN
        // Falling edge pairs with the latest rising pixel, still in wr_addr.
        else if (w_pix_fall && r_pend) begin
            w_wr_b    = 1'b1;
            w_data    = r_d2;
            w_pend_nx = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_FRAME;
            r_cnt       <= '0;
            wr_en_a     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            line_done   <= 1'b0;
            frame_start <= 1'b0;
            wr_bank     <= 1'b0;
            line_num    <= '0;
            short_line  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            wr_en_a     <= w_wr_a;
            wr_addr     <= w_addr;
            wr_data     <= w_data;
            line_done   <= w_done;
            frame_start <= w_fs;
            wr_bank     <= w_bank;
            line_num    <= w_line;
            short_line  <= w_short;
        end
    end

`ifdef NDS_CAPTURE_DUAL_EDGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= 1'b0;
            wr_en_b <= 1'b0;
        end else begin
            r_pend  <= w_pend_nx;
            wr_en_b <= w_wr_b;
        end
    end
`else
    assign wr_en_b = 1'b0;
`endif

endmodule

// File: tb/tb_nds_line_capture.sv
// tb_nds_line_capture: directed line/frame vectors for nds_line_capture,
// plus a small-geometry instance for end-of-frame behaviour.
module tb_nds_line_capture;

`ifdef NDS_CAPTURE_DUAL_EDGE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nds_pix_clk = 1'b0;
    logic        nds_hsync = 1'b1;
    logic        nds_vsync = 1'b1;
    logic [17:0] nds_data = '0;

    logic        wr_en_a, wr_en_b, wr_bank, line_done, frame_start, short_line;
    logic [7:0]  wr_addr, line_num;
    logic [17:0] wr_data;

    logic        s_wr_en_a, s_wr_en_b, s_wr_bank, s_line_done;
    logic        s_frame_start, s_short_line;
    logic [7:0]  s_wr_addr, s_line_num;
    logic [17:0] s_wr_data;

    always #5 clk = ~clk;

    nds_line_capture u_dut (
        .clk         (clk),
        .rst         (rst),
        .nds_pix_clk (nds_pix_clk),
        .nds_hsync   (nds_hsync),
        .nds_vsync   (nds_vsync),
        .nds_data    (nds_data),
        .wr_en_a     (wr_en_a),
        .wr_en_b     (wr_en_b),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .line_done   (line_done),
        .line_num    (line_num),
        .frame_start (frame_start),
        .short_line  (short_line)
    );

    nds_line_capture #(
        .H_PORCH  (2),
        .H_ACTIVE (8),
        .V_ACTIVE (4)
    ) u_small (
        .clk         (clk),
        .rst         (rst),
        .nds_pix_clk (nds_pix_clk),
        .nds_hsync   (nds_hsync),
        .nds_vsync   (nds_vsync),
        .nds_data    (nds_data),
        .wr_en_a     (s_wr_en_a),
        .wr_en_b     (s_wr_en_b),
        .wr_bank     (s_wr_bank),
        .wr_addr     (s_wr_addr),
        .wr_data     (s_wr_data),
        .line_done   (s_line_done),
        .line_num    (s_line_num),
        .frame_start (s_frame_start),
        .short_line  (s_short_line)
    );

    int a_addr[$];
    int a_data[$];
    int b_addr[$];
    int b_data[$];
    int n_done = 0;
    int n_fs   = 0;
    int s_wr   = 0;
    int s_done = 0;
    int s_fs   = 0;

    always @(negedge clk) begin
        if (wr_en_a) begin
            a_addr.push_back(int'(wr_addr));
            a_data.push_back(int'(wr_data));
        end
        if (wr_en_b) begin
            b_addr.push_back(int'(wr_addr));
            b_data.push_back(int'(wr_data));
        end
        if (line_done)     n_done++;
        if (frame_start)   n_fs++;
        if (s_wr_en_a)     s_wr++;
        if (s_line_done)   s_done++;
        if (s_frame_start) s_fs++;
    end

    int n_chk = 0;
    int n_err = 0;
    int a0, b0, d0, f0, sw0, sd0, sf0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        a0  = a_addr.size();
        b0  = b_addr.size();
        d0  = n_done;
        f0  = n_fs;
        sw0 = s_wr;
        sd0 = s_done;
        sf0 = s_fs;
    endtask

    task automatic pix(input int d);
        nds_data    = 18'(d);
        nds_pix_clk = 1'b1;
        step(2);
        nds_pix_clk = 1'b0;
        step(2);
    endtask

    task automatic hs_fall();
        nds_hsync = 1'b0;
        step(4);
        nds_hsync = 1'b1;
        step(4);
    endtask

    task automatic vs_fall();
        nds_vsync = 1'b0;
        step(4);
        nds_vsync = 1'b1;
        step(4);
    endtask

    typedef struct {
        int n_edges;
        int exp_wr;
        int exp_first;
        int exp_last_addr;
        int exp_last_data;
        int exp_done;
        int exp_line;
        int exp_bank;
        int exp_short;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int nw, mx, gba, gbd;

        tbl[0] = '{260, 256, 4, 255, 259, 1, 1, 1, 0};
        tbl[1] = '{100,  96, 4,  95,  99, 0, 1, 1, 1};
        tbl[2] = '{270, 256, 4, 255, 259, 1, 2, 0, 1};
        tbl[3] = '{  4,   0, 0,   0,   0, 0, 2, 0, 1};
        tbl[4] = '{  5,   1, 4,   0,   4, 0, 2, 0, 1};
        tbl[5] = '{260, 256, 4, 255, 259, 1, 3, 1, 1};

        step(3);
        chk("rst_wr_en_a",    32'(wr_en_a), 0);
        chk("rst_wr_en_b",    32'(wr_en_b), 0);
        chk("rst_wr_bank",    32'(wr_bank), 0);
        chk("rst_wr_addr",    32'(wr_addr), 0);
        chk("rst_wr_data",    32'(wr_data), 0);
        chk("rst_line_num",   32'(line_num), 0);
        chk("rst_short_line", 32'(short_line), 0);
        chk("rst_strobes",    32'({line_done, frame_start}), 0);
        rst = 1'b0;
        step(4);

        mark();
        vs_fall();
        chk("frame_start_cnt", 32'(n_fs - f0), 1);
        chk("line_num_after_vs", 32'(line_num), 0);
        hs_fall();

        for (int r = 0; r < 6; r++) begin
            mark();
            for (int i = 0; i < tbl[r].n_edges; i++) pix(i);
            step(3);
            hs_fall();
            nw = a_addr.size() - a0;
            chk($sformatf("v%0d_writes", r), 32'(nw), 32'(tbl[r].exp_wr));
            chk($sformatf("v%0d_wr_en_b", r), 32'(b_addr.size() - b0),
                32'(DUAL ? tbl[r].exp_wr : 0));
            if (nw > 0) begin
                mx = 0;
                for (int k = a0; k < a_addr.size(); k++)
                    if (a_addr[k] > mx) mx = a_addr[k];
                chk($sformatf("v%0d_first_addr", r), 32'(a_addr[a0]), 0);
                chk($sformatf("v%0d_first_data", r), 32'(a_data[a0]),
                    32'(tbl[r].exp_first));
                chk($sformatf("v%0d_last_addr", r), 32'(a_addr[$]),
                    32'(tbl[r].exp_last_addr));
                chk($sformatf("v%0d_last_data", r), 32'(a_data[$]),
                    32'(tbl[r].exp_last_data));
                chk($sformatf("v%0d_max_addr", r), 32'(mx),
                    32'(tbl[r].exp_last_addr));
            end
            chk($sformatf("v%0d_line_done", r), 32'(n_done - d0),
                32'(tbl[r].exp_done));
            chk($sformatf("v%0d_line_num", r), 32'(line_num),
                32'(tbl[r].exp_line));
            chk($sformatf("v%0d_wr_bank", r), 32'(wr_bank),
                32'(tbl[r].exp_bank));
            chk($sformatf("v%0d_short", r), 32'(short_line),
                32'(tbl[r].exp_short));
        end

        // Pixel 10 of a line: exact 3-cycle latency and the paired B write.
        for (int i = 0; i < 10; i++) pix(i);
        mark();
        nds_data    = 18'h0AAAA;
        nds_pix_clk = 1'b1;
        step(1);
        chk("lat_cyc1", 32'(wr_en_a), 0);
        step(1);
        chk("lat_cyc2", 32'(wr_en_a), 0);
        step(1);
        chk("lat_cyc3", 32'(wr_en_a), 1);
        chk("lat_addr", 32'(wr_addr), 6);
        chk("lat_data", 32'(wr_data), 32'h0AAAA);
        step(1);
        chk("lat_pulse_width", 32'(wr_en_a), 0);
        nds_data    = 18'h15555;
        nds_pix_clk = 1'b0;
        step(5);
        gba = (b_addr.size() > b0) ? b_addr[$] : 0;
        gbd = (b_data.size() > b0) ? b_data[$] : 0;
        chk("dual_b_cnt",  32'(b_addr.size() - b0), 32'(DUAL ? 1 : 0));
        chk("dual_b_addr", 32'(gba), 32'(DUAL ? 6 : 0));
        chk("dual_b_data", 32'(gbd), 32'(DUAL ? 32'h15555 : 0));

        // vsync fall mid-line at addr 50.
        mark();
        for (int i = 11; i < 55; i++) pix(i);
        step(3);
        vs_fall();
        chk("abort_last_addr", 32'(a_addr[$]), 50);
        chk("abort_fs",        32'(n_fs - f0), 1);
        chk("abort_no_done",   32'(n_done - d0), 0);
        chk("abort_wr_bank",   32'(wr_bank), 0);
        chk("abort_line_num",  32'(line_num), 0);

        // Reset with a rising-edge write still in the pipeline.
        hs_fall();
        for (int i = 0; i < 20; i++) pix(i);
        nds_data    = 18'h3;
        nds_pix_clk = 1'b1;
        step(1);
        mark();
        rst = 1'b1;
        #1;
        chk("midrst_outs",
            32'({wr_en_a, wr_en_b, wr_bank, line_done, frame_start}), 0);
        chk("midrst_addr_data", 32'({wr_addr, wr_data}), 0);
        chk("midrst_line_short", 32'({line_num, short_line}), 0);
        step(2);
        rst = 1'b0;
        nds_pix_clk = 1'b0;
        step(6);
        chk("midrst_no_pending", 32'(a_addr.size() - a0), 0);
        hs_fall();
        for (int i = 0; i < 20; i++) pix(i);
        step(3);
        hs_fall();
        chk("midrst_idle_writes", 32'(a_addr.size() - a0), 0);
        chk("midrst_idle_done",   32'(n_done - d0), 0);
        chk("midrst_idle_short",  32'(short_line), 0);
        vs_fall();
        chk("midrst_fs", 32'(n_fs - f0), 1);
        hs_fall();
        mark();
        for (int i = 0; i < 30; i++) pix(i);
        step(3);
        vs_fall();
        chk("resume_writes",  32'(a_addr.size() - a0), 26);
        chk("resume_abort_short", 32'(short_line), 0);
        chk("resume_abort_done",  32'(n_done - d0), 0);

        // End of frame on the small instance: line V_ACTIVE is ignored.
        mark();
        hs_fall();
        for (int l = 0; l < 5; l++) begin
            sw0 = s_wr;
            sd0 = s_done;
            for (int i = 0; i < 10; i++) pix(i);
            step(3);
            hs_fall();
            chk($sformatf("frm_l%0d_writes", l), 32'(s_wr - sw0),
                32'((l < 4) ? 8 : 0));
            chk($sformatf("frm_l%0d_done", l), 32'(s_done - sd0),
                32'((l < 4) ? 1 : 0));
        end
        sf0 = s_fs;
        vs_fall();
        chk("frm_restart_fs",   32'(s_fs - sf0), 1);
        chk("frm_restart_line", 32'(s_line_num), 0);
        hs_fall();
        sw0 = s_wr;
        for (int i = 0; i < 10; i++) pix(i);
        step(3);
        hs_fall();
        chk("frm_restart_writes", 32'(s_wr - sw0), 8);
        chk("frm_restart_line1",  32'(s_line_num), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/nds_line_capture.md
NDS_LINE_CAPTURE -- requirements
Module: nds_line_capture

Interface
REQ-001 SHALL have parameter H_PORCH, default 4: NDS pixel clocks discarded after hsync fall before the first active pixel.
REQ-002 SHALL have parameter H_ACTIVE, default 256: active pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 192: active lines per frame.
REQ-004 SHALL have ports:
- clk  input  1  capture clock, 54 MHz DCM output; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- nds_pix_clk  input  1  NDS pixel clock, asynchronous to clk.
- nds_hsync  input  1  NDS hsync, active-low, asynchronous.
- nds_vsync  input  1  NDS vsync, active-low, asynchronous.
- nds_data  input  18  NDS pixel: R 5:0, G 11:6, B 17:12.
- wr_en_a  output  1  line-buffer write strobe, screen A (pix_clk rising edge).
- wr_en_b  output  1  line-buffer write strobe, screen B (pix_clk falling edge).
- wr_bank  output  1  ping-pong bank select being written.
- wr_addr  output  8  pixel index 0..H_ACTIVE-1.
- wr_data  output  18  pixel written.
- line_done  output  1  one-cycle pulse: a complete line is in wr_bank's previous value.
- line_num  output  8  index of the line currently being captured.
- frame_start  output  1  one-cycle pulse on synchronized vsync fall.
- short_line  output  1  sticky error: a line ended with fewer than H_ACTIVE pixels.

Function
REQ-005 SHALL pass nds_pix_clk, nds_hsync, nds_vsync through 2-FF synchronizers with registered edge detection; nds_data SHALL be delayed by the same depth so that it aligns with the detected edge.
REQ-006 SHALL assert wr_en_a exactly 3 clk cycles after a nds_pix_clk rising edge at the pin, for one cycle.
REQ-007 SHALL implement states WAIT_FRAME, WAIT_LINE, PORCH, ACTIVE, TAIL.
REQ-008 WAIT_FRAME -> WAIT_LINE on vsync fall; WAIT_LINE -> PORCH on hsync fall; PORCH -> ACTIVE after H_PORCH rising edges; ACTIVE -> TAIL after H_ACTIVE writes; TAIL -> PORCH on hsync fall.
REQ-009 In ACTIVE, each rising edge SHALL write wr_addr = pixel count minus H_PORCH; pixels in PORCH and TAIL SHALL be discarded.
REQ-010 On hsync fall from TAIL: line_done pulses, wr_bank toggles, line_num increments; when line_num would reach V_ACTIVE, state SHALL go to WAIT_FRAME.
REQ-011 On hsync fall from PORCH or ACTIVE: short_line sets; line_done, wr_bank and line_num are unchanged; the line restarts in PORCH with addr 0.
REQ-012 vsync fall in any state SHALL pulse frame_start, clear line_num and wr_bank, and go to WAIT_LINE; any partial line is aborted without line_done and without setting short_line.
REQ-013 A pix_clk edge in the same cycle as hsync fall SHALL be discarded and not counted; vsync fall SHALL take priority over hsync fall.
REQ-014 wr_addr SHALL never exceed H_ACTIVE-1; the pixel counter SHALL saturate in TAIL.

Reset
REQ-015 On rst: state WAIT_FRAME; all strobes, wr_bank, wr_addr, wr_data, line_num and short_line are 0; synchronizers cleared.
REQ-016 rst asserted mid-line SHALL drop any pending write with no partial strobe after deassertion.

Configuration
REQ-017 With NDS_CAPTURE_DUAL_EDGE_EN defined: each pix_clk falling edge in ACTIVE SHALL assert wr_en_b with wr_addr of the most recent rising-edge pixel; the counter advances on rising edges only.
REQ-018 Without NDS_CAPTURE_DUAL_EDGE_EN: wr_en_b SHALL be tied 0 and no falling-edge logic is built.

Structure
REQ-019 Package nds_capture_pkg SHALL hold the 18-bit pixel typedef, the state enum, and the H_ACTIVE/V_ACTIVE/H_PORCH defaults.
REQ-020 Sub-module nds_sync_edge (2-FF synchronizer plus rise/fall pulse) SHALL be instantiated once per asynchronous control input.

Verification
REQ-021 vsync fall, hsync fall, 260 pix_clk edges with data = index -> addr 0..255 written with data 4..259, then on next hsync fall line_done=1, wr_bank=1, line_num=1.
REQ-022 hsync fall after 100 edges -> short_line=1, no line_done, line_num unchanged, next line starts at addr 0.
REQ-023 193 complete lines -> line 192 is ignored (no writes), state WAIT_FRAME until the next vsync fall; frame_start then pulses and line_num=0.
REQ-024 vsync fall at addr 50 -> frame_start pulse, no line_done, wr_bank=0.
REQ-025 Dual-edge build, rising data 0xAAAA, falling data 0x15555 at pixel 10 -> wr_en_a addr 6 with 0xAAAA, then wr_en_b addr 6 with 0x15555; single-edge build -> wr_en_b stays 0.
REQ-026 rst pulse mid-ACTIVE -> all outputs 0 and no strobes until vsync fall followed by hsync fall.
